// File: rtl/lms_ctrl_pkg.sv
// Purpose: shared state encoding and energy-filter constant for the LMS step scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lms_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WARMUP = 3'd2,
        ST_TRAIN  = 3'd3,
        ST_TRACK  = 3'd4,
        ST_FAULT  = 3'd5
    } lms_state_t;

    // Leaky-integrator shift for the error-energy estimate: E += (|e| - E) / 16.
    localparam int ENERGY_SHIFT = 4;

endpackage

// File: rtl/err_energy_mon.sv
// Purpose: error magnitude (saturating abs), leaky error energy E and divergence flag.
// Latency: |e| combinational; E updates on the clk edge that samples i_en; o_div follows registered E.
// Backpressure: none; an update is taken on every cycle with i_en high.
module err_energy_mon
    import lms_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_THRESH = 1 << 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_error,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_div
);

    localparam logic [WIDTH-1:0] L_MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] L_MAG_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] L_DIV_THRESH = WIDTH'(DIV_THRESH);

    logic [WIDTH-1:0] r_energy;
    logic [WIDTH-1:0] w_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_energy_nxt;

    // Saturating absolute value and saturating leaky update of the energy estimate.
    always_comb begin
        w_mag = i_error;
        if (i_error == L_MOST_NEG) begin
            w_mag = L_MAG_MAX;
        end else if (i_error[WIDTH-1]) begin
            w_mag = -i_error;
        end
        // E - (E>>4) never underflows; only the add can carry out of WIDTH bits.
        w_sum = {1'b0, r_energy - (r_energy >> ENERGY_SHIFT)} + {1'b0, w_mag >> ENERGY_SHIFT};
        w_energy_nxt = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end

    // Energy register: cleared at run start, updated only on accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_energy <= '0;
        end else if (i_clr) begin
            r_energy <= '0;
        end else if (i_en) begin
            r_energy <= w_energy_nxt;
        end
    end

    assign o_mag = w_mag;
    assign o_div = (r_energy > L_DIV_THRESH);

endmodule

// File: rtl/lms_step_scheduler.sv
// Purpose: LMS step-size scheduler (clear, warm-up, train with optional anneal, track, fault).
// Latency: all outputs registered; a state change is visible one cycle after the edge that samples its cause.
// Backpressure: none; i_valid samples are always consumed. Anneal logic present only with LMS_STEP_ANNEAL_EN.
module lms_step_scheduler
    import lms_ctrl_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FRAC         = 20,
    parameter int TAPS         = 2,
    parameter int MU_INIT      = 1 << (FRAC - 4),
    parameter int MU_MIN       = 1 << (FRAC - 10),
    parameter int HOLD_SAMPLES = 256,
    parameter int CONV_THRESH  = 1 << (FRAC - 8),
    parameter int CONV_COUNT   = 64,
    parameter int DIV_THRESH   = 1 << (FRAC + 4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_error,
    input  logic             i_ovr,
    output logic [WIDTH-1:0] o_step_size,
    output logic             o_clear,
    output logic [2:0]       o_state,
    output logic             o_converged,
    output logic             o_diverged,
    output logic             o_busy
);

    localparam int WARM_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CONV_W = $clog2(CONV_COUNT + 1);

    localparam logic [WIDTH-1:0]  L_MU_INIT   = WIDTH'(MU_INIT);
    localparam logic [WIDTH-1:0]  L_MU_MIN    = WIDTH'(MU_MIN);
    localparam logic [WIDTH-1:0]  L_SMALL_LIM = WIDTH'(CONV_THRESH);
    localparam logic [WIDTH-1:0]  L_BIG_LIM   = WIDTH'(4 * CONV_THRESH);
    localparam logic [WARM_W-1:0] L_WARM_LOAD = WARM_W'(TAPS - 1);
    localparam logic [CONV_W-1:0] L_CONV_LAST = CONV_W'(CONV_COUNT - 1);

    lms_state_t       r_state;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_mu;
    logic             r_clear;
    logic             r_conv;
    logic             r_div;
    logic             r_busy;
    logic [WARM_W-1:0] r_warm_cnt;
    logic [CONV_W-1:0] r_conv_cnt;

    logic [WIDTH-1:0] w_mag;
    logic             w_div;
    logic             w_active;
    logic             w_fault;
    logic             w_small;
    logic             w_big;
    logic             w_energy_en;
    logic             w_energy_clr;

`ifdef LMS_STEP_ANNEAL_EN
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam logic [HOLD_W-1:0] L_HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [WIDTH-1:0]  w_mu_half;

    // Next annealed step size, floored at MU_MIN.
    always_comb begin
        w_mu_half = r_mu >> 1;
        if (w_mu_half < L_MU_MIN) begin
            w_mu_half = L_MU_MIN;
        end
    end
`endif

    err_energy_mon #(
        .WIDTH      (WIDTH),
        .DIV_THRESH (DIV_THRESH)
    ) u_energy (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_energy_en),
        .i_clr   (w_energy_clr),
        .i_error (i_error),
        .o_mag   (w_mag),
        .o_div   (w_div)
    );

    // Qualifiers: fault sources, error-size classes and energy update enables.
    always_comb begin
        w_active     = (r_state == ST_WARMUP) || (r_state == ST_TRAIN) || (r_state == ST_TRACK);
        w_fault      = w_active && (i_ovr || w_div);
        w_small      = (w_mag < L_SMALL_LIM);
        w_big        = (w_mag >= L_BIG_LIM);
        w_energy_en  = i_valid && ((r_state == ST_TRAIN) || (r_state == ST_TRACK));
        w_energy_clr = (r_state == ST_CLEAR);
    end

    // Control FSM with registered outputs; abort beats fault beats convergence beats anneal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_mu       <= L_MU_INIT;
            r_clear    <= 1'b0;
            r_conv     <= 1'b0;
            r_div      <= 1'b0;
            r_busy     <= 1'b0;
            r_warm_cnt <= '0;
            r_conv_cnt <= '0;
`ifdef LMS_STEP_ANNEAL_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_clear <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
                r_step  <= '0;
                r_conv  <= 1'b0;
                r_div   <= 1'b0;
                r_busy  <= 1'b0;
            end else if (w_fault) begin
                r_state <= ST_FAULT;
                r_step  <= '0;
                r_conv  <= 1'b0;
                r_div   <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_FAULT: begin
                        if (i_start) begin
                            r_state <= ST_CLEAR;
                            r_clear <= 1'b1;
                            r_div   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        r_state    <= ST_WARMUP;
                        r_warm_cnt <= L_WARM_LOAD;
                        r_conv_cnt <= '0;
                        r_mu       <= L_MU_INIT;
`ifdef LMS_STEP_ANNEAL_EN
                        r_hold_cnt <= '0;
`endif
                    end
                    ST_WARMUP: begin
                        if (i_valid) begin
                            if (r_warm_cnt == '0) begin
                                r_state <= ST_TRAIN;
                                r_step  <= r_mu;
                            end else begin
                                r_warm_cnt <= r_warm_cnt - 1'b1;
                            end
                        end
                    end
                    ST_TRAIN: begin
                        if (i_valid) begin
                            if (w_small && (r_conv_cnt == L_CONV_LAST)) begin
                                r_state    <= ST_TRACK;
                                r_step     <= L_MU_MIN;
                                r_conv     <= 1'b1;
                                r_conv_cnt <= '0;
                            end else begin
                                r_conv_cnt <= w_small ? r_conv_cnt + 1'b1 : '0;
`ifdef LMS_STEP_ANNEAL_EN
                                if (r_hold_cnt == L_HOLD_LAST) begin
                                    r_hold_cnt <= '0;
                                    r_mu       <= w_mu_half;
                                    r_step     <= w_mu_half;
                                end else begin
                                    r_hold_cnt <= r_hold_cnt + 1'b1;
                                end
`endif
                            end
                        end
                    end
                    ST_TRACK: begin
                        if (i_valid) begin
                            if (w_big && (r_conv_cnt == L_CONV_LAST)) begin
                                r_state    <= ST_TRAIN;
                                r_mu       <= L_MU_INIT;
                                r_step     <= L_MU_INIT;
                                r_conv     <= 1'b0;
                                r_conv_cnt <= '0;
`ifdef LMS_STEP_ANNEAL_EN
                                r_hold_cnt <= '0;
`endif
                            end else begin
                                r_conv_cnt <= w_big ? r_conv_cnt + 1'b1 : '0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_step  <= '0;
                        r_conv  <= 1'b0;
                        r_div   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_step_size = r_step;
    assign o_clear     = r_clear;
    assign o_state     = r_state;
    assign o_converged = r_conv;
    assign o_diverged  = r_div;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_lms_step_scheduler.sv
module tb_lms_step_scheduler;

    localparam int WIDTH      = 32;
    localparam int FRAC       = 20;
    localparam int TAPS       = 4;
    localparam int HOLD       = 8;
    localparam int CCOUNT     = 4;
    localparam logic [31:0] MU_INIT = 32'd65536;
    localparam logic [31:0] MU_MIN  = 32'd1024;
    localparam logic [31:0] ONE     = 32'h0010_0000;
    localparam logic [31:0] NEG_MAX = 32'h8000_0000;

    localparam int S_IDLE = 0, S_CLEAR = 1, S_WARM = 2, S_TRAIN = 3, S_TRACK = 4, S_FAULT = 5;

    typedef struct packed {
        logic [2:0]  state;
        logic [31:0] step;
        logic        clr;
        logic        conv;
        logic        div;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_error = '0;
    logic        i_ovr = 1'b0;
    logic [31:0] o_step_size;
    logic        o_clear;
    logic [2:0]  o_state;
    logic        o_converged;
    logic        o_diverged;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    lms_step_scheduler #(
        .WIDTH        (WIDTH),
        .FRAC         (FRAC),
        .TAPS         (TAPS),
        .HOLD_SAMPLES (HOLD),
        .CONV_COUNT   (CCOUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_valid     (i_valid),
        .i_error     (i_error),
        .i_ovr       (i_ovr),
        .o_step_size (o_step_size),
        .o_clear     (o_clear),
        .o_state     (o_state),
        .o_converged (o_converged),
        .o_diverged  (o_diverged),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected outputs for a state; flags follow from the state's definition.
    function automatic exp_t ex(input int st, input logic [31:0] stp, input logic clr);
        exp_t e;
        e.state = 3'(st);
        e.step  = stp;
        e.clr   = clr;
        e.conv  = (st == S_TRACK);
        e.div   = (st == S_FAULT);
        e.busy  = (st >= S_CLEAR) && (st <= S_TRACK);
        return e;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".state"}, 64'(o_state), 64'(e.state));
        chk({tag, ".step"},  64'(o_step_size), 64'(e.step));
        chk({tag, ".clear"}, 64'(o_clear), 64'(e.clr));
        chk({tag, ".conv"},  64'(o_converged), 64'(e.conv));
        chk({tag, ".div"},   64'(o_diverged), 64'(e.div));
        chk({tag, ".busy"},  64'(o_busy), 64'(e.busy));
    endtask

    // One clock of stimulus; expectation is queued with it and checked after the edge.
    task automatic cyc(input string tag, input logic st, input logic ab, input logic vl,
                       input logic [31:0] err, input logic ov, input exp_t e);
        i_start = st;
        i_abort = ab;
        i_valid = vl;
        i_error = err;
        i_ovr   = ov;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_valid = 1'b0;
        i_ovr   = 1'b0;
        compare_out(tag);
    endtask

    // Start a run and walk through CLEAR and warm-up into TRAIN.
    task automatic start_to_train(input string tag);
        cyc({tag, ".start"}, 1, 0, 0, 0, 0, ex(S_CLEAR, 0, 1));
        cyc({tag, ".clear"}, 0, 0, 0, 0, 0, ex(S_WARM, 0, 0));
        for (int i = 0; i < TAPS - 1; i++)
            cyc({tag, ".warm"}, 0, 0, 1, 0, 0, ex(S_WARM, 0, 0));
        cyc({tag, ".train"}, 0, 0, 1, 0, 0, ex(S_TRAIN, MU_INIT, 0));
    endtask

    initial begin
        logic [31:0] mu_exp;

        // Reset state while rst is held.
        #2;
        exp_q.push_back(ex(S_IDLE, 0, 0));
        compare_out("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // No start: valid samples and overflow leave IDLE alone.
        cyc("idle_valid", 0, 0, 1, ONE, 1, ex(S_IDLE, 0, 0));

        // Start flow with an ignored start and an idle gap during warm-up.
        cyc("sf.start", 1, 0, 0, 0, 0, ex(S_CLEAR, 0, 1));
        cyc("sf.clear", 1, 0, 0, 0, 0, ex(S_WARM, 0, 0));
        cyc("sf.w1", 0, 0, 1, ONE, 0, ex(S_WARM, 0, 0));
        cyc("sf.gap", 1, 0, 0, ONE, 0, ex(S_WARM, 0, 0));
        cyc("sf.w2", 0, 0, 1, ONE, 0, ex(S_WARM, 0, 0));
        cyc("sf.w3", 0, 0, 1, ONE, 0, ex(S_WARM, 0, 0));
        cyc("sf.w4", 0, 0, 1, ONE, 0, ex(S_TRAIN, MU_INIT, 0));

        // Anneal with error 1.0; idle cycles between samples must not count.
        for (int k = 1; k <= 60; k++) begin
`ifdef LMS_STEP_ANNEAL_EN
            mu_exp = MU_INIT >> (k / HOLD);
            if (mu_exp < MU_MIN) mu_exp = MU_MIN;
`else
            mu_exp = MU_INIT;
`endif
            cyc("anneal", 0, 0, 1, ONE, 0, ex(S_TRAIN, mu_exp, 0));
            if (k % 5 == 0)
                cyc("anneal.gap", 1, 0, 0, 0, 0, ex(S_TRAIN, mu_exp, 0));
        end

        // Abort beats overflow in TRAIN.
        cyc("abort", 0, 1, 1, ONE, 1, ex(S_IDLE, 0, 0));

        // Convergence: 3 small, 1 large, then 4 small (one at the -4095 boundary).
        start_to_train("cv");
        for (int i = 0; i < 3; i++) cyc("cv.small", 0, 0, 1, 0, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("cv.big", 0, 0, 1, ONE, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("cv.s1", 0, 0, 1, -32'sd4095, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("cv.s2", 0, 0, 1, 0, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("cv.s3", 0, 0, 1, 0, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("cv.s4", 0, 0, 1, 0, 0, ex(S_TRACK, MU_MIN, 0));

        // Reacquire: |e| = 4*thresh counts as large; a small sample restarts the run.
        for (int i = 0; i < 3; i++) cyc("rq.big", 0, 0, 1, 32'd16384, 0, ex(S_TRACK, MU_MIN, 0));
        cyc("rq.small", 0, 0, 1, 32'd16383, 0, ex(S_TRACK, MU_MIN, 0));
        for (int i = 0; i < 3; i++) cyc("rq.big2", 0, 0, 1, ONE, 0, ex(S_TRACK, MU_MIN, 0));
        cyc("rq.train", 0, 0, 1, ONE, 0, ex(S_TRAIN, MU_INIT, 0));

        // |e| = 4096 is not small: the convergence run must restart.
        for (int i = 0; i < 3; i++) cyc("th.small", 0, 0, 1, 0, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("th.edge", 0, 0, 1, 32'd4096, 0, ex(S_TRAIN, MU_INIT, 0));
        for (int i = 0; i < 3; i++) cyc("th.small2", 0, 0, 1, 0, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("th.track", 0, 0, 1, 0, 0, ex(S_TRACK, MU_MIN, 0));

        // Asynchronous reset mid-TRACK, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(ex(S_IDLE, 0, 0));
        compare_out("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst", 0, 0, 1, 0, 0, ex(S_IDLE, 0, 0));

        // Fault beats convergence on the same sample.
        start_to_train("fp");
        for (int i = 0; i < 3; i++) cyc("fp.small", 0, 0, 1, 0, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("fp.ovr", 0, 0, 1, 0, 1, ex(S_FAULT, 0, 0));
        cyc("fp.hold", 0, 0, 1, 0, 0, ex(S_FAULT, 0, 0));
        cyc("fp.restart", 1, 0, 0, 0, 0, ex(S_CLEAR, 0, 1));
        cyc("fp.clear", 0, 0, 0, 0, 0, ex(S_WARM, 0, 0));

        // Overflow without a valid sample still faults in WARMUP.
        cyc("ovr_novalid", 0, 0, 0, 0, 1, ex(S_FAULT, 0, 0));

        // Most negative error: saturated |e| drives E over threshold, no wrap.
        start_to_train("sat");
        cyc("sat.sample", 0, 0, 1, NEG_MAX, 0, ex(S_TRAIN, MU_INIT, 0));
        cyc("sat.fault", 0, 0, 0, 0, 0, ex(S_FAULT, 0, 0));

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
